// File: rtl/dma_copy_engine.sv
// Word-granular memory-to-memory copy engine: one read then one write per word on a
// req/gnt/rvalid bus, one transaction outstanding, per-phase timeout abort.
module dma_copy_engine #(
  parameter int TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] src_addr,
  input  logic [31:0] dst_addr,
  input  logic [15:0] word_count,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        data_req,
  output logic        data_we,
  output logic [3:0]  data_be,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_gnt,
  input  logic        data_rvalid,
  input  logic [31:0] data_rdata
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    WR_WAIT,
    FINISH
  } state_t;

  state_t        state;
  logic [31:0]   src_ptr;
  logic [31:0]   dst_ptr;
  logic [15:0]   remaining;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;

  // Last permitted cycle of the current phase; the awaited event did not arrive in time.
  assign tmo_hit = (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      src_ptr    <= '0;
      dst_ptr    <= '0;
      remaining  <= '0;
      tmo_cnt    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      data_req   <= 1'b0;
      data_we    <= 1'b0;
      data_be    <= 4'h0;
      data_addr  <= '0;
      data_wdata <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            src_ptr   <= src_addr & WORD_MASK;
            dst_ptr   <= dst_addr & WORD_MASK;
            remaining <= word_count;
            tmo_cnt   <= '0;
            error     <= 1'b0;
            busy      <= 1'b1;
            if (word_count != 16'd0) begin
              state     <= RD_REQ;
              data_req  <= 1'b1;
              data_we   <= 1'b0;
              data_be   <= 4'hF;
              data_addr <= src_addr & WORD_MASK;
            end else begin
              state <= FINISH;
            end
          end
        end

        RD_REQ: begin
          if (data_gnt) begin
            state    <= RD_WAIT;
            data_req <= 1'b0;
            data_be  <= 4'h0;
            tmo_cnt  <= '0;
          end else if (tmo_hit) begin
            state    <= FINISH;
            data_req <= 1'b0;
            data_be  <= 4'h0;
            error    <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end

        RD_WAIT: begin
          if (data_rvalid) begin
            data_wdata <= data_rdata;
            state      <= WR_REQ;
            data_req   <= 1'b1;
            data_we    <= 1'b1;
            data_be    <= 4'hF;
            data_addr  <= dst_ptr;
            tmo_cnt    <= '0;
          end else if (tmo_hit) begin
            state <= FINISH;
            error <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end

        WR_REQ: begin
          if (data_gnt) begin
            state    <= WR_WAIT;
            data_req <= 1'b0;
            data_be  <= 4'h0;
            tmo_cnt  <= '0;
          end else if (tmo_hit) begin
            state    <= FINISH;
            data_req <= 1'b0;
            data_be  <= 4'h0;
            error    <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end

        // Word complete: pointers wrap modulo 2^32, next read issues straight away.
        WR_WAIT: begin
          if (data_rvalid) begin
            remaining <= remaining - 16'd1;
            src_ptr   <= src_ptr + 32'd4;
            dst_ptr   <= dst_ptr + 32'd4;
            tmo_cnt   <= '0;
            if (remaining == 16'd1) begin
              state <= FINISH;
            end else begin
              state     <= RD_REQ;
              data_req  <= 1'b1;
              data_we   <= 1'b0;
              data_be   <= 4'hF;
              data_addr <= src_ptr + 32'd4;
            end
          end else if (tmo_hit) begin
            state <= FINISH;
            error <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end

        FINISH: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/dma_copy_engine.md
# dma_copy_engine

Word-granular memory-to-memory copy engine that acts as an initiator on the data bus (req/gnt/rvalid protocol) served by the peripheral and memory responders. Started by a single-cycle pulse with source, destination and word count. It then alternates one read and one write transaction per word, with exactly one outstanding transaction at a time. A per-transaction timeout aborts the copy if a responder never grants or never returns rvalid, so a bad address cannot hang the engine.

## Interface
- TIMEOUT, 256: maximum cycles spent waiting for gnt or rvalid in any one transaction phase before abort (≥2).
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a copy; sampled only while busy=0.
- src_addr  in  32  source byte address; bits [1:0] ignored (forced 0).
- dst_addr  in  32  destination byte address; bits [1:0] ignored.
- word_count  in  16  number of 32-bit words to copy; 0 is legal.
- busy  out  1  high while a copy is in progress.
- done  out  1  one-cycle pulse at end of copy (normal or aborted).
- error  out  1  set on timeout abort; held until next accepted start or rst.
- data_req  out  1  transaction request.
- data_we  out  1  1 = write, 0 = read.
- data_be  out  4  byte enables; always 4'b1111 during a request.
- data_addr  out  32  word-aligned transaction address.
- data_wdata  out  32  write data (last read word).
- data_gnt  in  1  responder grant.
- data_rvalid  in  1  responder completion; read data valid.
- data_rdata  in  32  read data, sampled when data_rvalid=1 in RD_WAIT.

## Operation
- Reset values (all outputs): busy 0, done 0, error 0, data_req 0, data_we 0, data_be 0, data_addr 0, data_wdata 0. State IDLE; internal counters 0.
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, FINISH.
- IDLE: on start=1, latch src/dst with [1:0]=0, latch word_count, clear error, busy←1. Next state is RD_REQ if count≠0, else FINISH.
- RD_REQ: data_req=1, we=0, be=F, addr=src pointer, all stable until gnt. When gnt is sampled 1, go to RD_WAIT and drop req in the next cycle.
- RD_WAIT: data_req=0. When rvalid is sampled 1, capture rdata into data_wdata, go to WR_REQ.
- WR_REQ: req=1, we=1, be=F, addr=dst pointer, wdata held. When gnt is sampled 1, go to WR_WAIT.
- WR_WAIT: when rvalid is sampled 1, decrement the remaining count and advance both pointers by 4.
  - If the remaining count is now 0, go to FINISH; otherwise go to RD_REQ.
- FINISH: done=1 for one cycle, busy←0, go to IDLE.
- Pointer arithmetic is 32-bit modulo: 0xFFFFFFFC + 4 wraps to 0x00000000 with no error.
- Timeout:
  - The counter clears on entry to each REQ/WAIT state and increments each cycle spent there.
  - If it reaches TIMEOUT without the awaited gnt/rvalid, drop req, set error=1 and go to FINISH.
  - Remaining words are not transferred.
- start while busy=1 is ignored. start in the FINISH cycle is ignored; it is accepted in IDLE only.
- gnt seen in a WAIT state and rvalid seen in a REQ state are ignored.
- rst mid-copy: next edge returns every output to its reset value; the transaction in flight is abandoned.

## Timing
- req asserts the cycle after entering RD_REQ/WR_REQ is registered, i.e. 1 cycle after accepted start for the first read.
- req deasserts in the cycle immediately after the cycle gnt=1 is sampled. It is never high for two cycles after a gnt, so a registered-gnt responder cannot double-grant.
- rvalid is expected ≥1 cycle after gnt.
- Against a responder with registered gnt (1 cycle after req) and rvalid (1 cycle after gnt), each word takes 6 cycles: RD_REQ, gnt, RD_WAIT/rvalid, WR_REQ, gnt, WR_WAIT/rvalid.
- A copy of N words ends with done exactly 6N+2 cycles after the start cycle.
- word_count=0: done is asserted 2 cycles after start, with no bus activity.
- busy rises the cycle after start and falls in the same cycle done pulses.

## Test plan
- Single word, zero-wait responder: mem[0x1000]=0xDEADBEEF, start src=0x1000 dst=0x2000 count=1 -> read at 0x1000 then write 0xDEADBEEF at 0x2000, be=F. done 8 cycles after start, error=0.
- Burst with stalls: count=4, responder inserts 0–3 random gnt and rvalid delays -> 4 reads at 0x100,104,108,10C and 4 writes of the matching data at the destination. req never asserted while awaiting rvalid; at most one outstanding transaction.
- Zero count and unaligned addresses:
  - count=0 -> no req, done 2 cycles after start.
  - src=0x1003, count=1 -> read address 0x1000.
- Timeout: TIMEOUT=8, responder never grants the second read of count=3 -> req drops after 8 cycles, done pulses, error=1. Exactly 1 write occurred.
- Wrap and ignored start: src=0xFFFFFFFC, count=2 -> second read at 0x00000000. start pulsed mid-copy -> no effect on addresses or count.
- Reset mid-copy: rst=1 during WR_REQ -> next cycle data_req=0, busy=0, done=0, error=0. A new start afterward copies correctly.
